// File: rtl/branch_target_stage.sv
// branch_target_stage: computes the branch target and the taken decision from the shifted offset and PC+4, and registers them behind a valid/ready handshake with a one-entry skid buffer.
//   clk_i, rst_i (async, active-low)
//   in_valid_i/in_ready_o: upstream handshake
//   pc_plus4_i, offset_sl2_i, branch_i, bne_i, zero_i: branch operands
//   flush_i: kills held and incoming entries
//   out_valid_o/out_ready_i: downstream handshake
//   target_o, taken_o, branch_o, misalign_o: registered result
//   Optional macro BRANCH_TARGET_STATS_EN adds branch_cnt_o/taken_cnt_o drain counters.
module branch_target_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic [ADDR_W-1:0] offset_sl2_i,
    input  logic              branch_i,
    input  logic              bne_i,
    input  logic              zero_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] target_o,
    output logic              taken_o,
    output logic              branch_o,
    output logic              misalign_o
`ifdef BRANCH_TARGET_STATS_EN
    ,
    output logic [31:0]       branch_cnt_o,
    output logic [31:0]       taken_cnt_o
`endif
);
    localparam int EW = ADDR_W + 3;

    // Entry layout: {taken, branch, misalign, target}
    logic [EW-1:0] in_e, m_e, s_e;
    logic          m_valid, s_valid;
    logic          accept, drain;

    assign in_e = {branch_i & (zero_i ^ bne_i), branch_i, |offset_sl2_i[1:0], pc_plus4_i + offset_sl2_i};
    assign in_ready_o  = ~s_valid;
    assign out_valid_o = m_valid;
    assign {taken_o, branch_o, misalign_o, target_o} = m_e;
    assign accept = in_valid_i & in_ready_o;
    assign drain  = m_valid & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_e     <= '0;
            s_e     <= '0;
        end else if (flush_i) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (s_valid) begin
            // FULL: in_ready_o is low, so only a drain can move the skid entry forward
            if (drain) begin
                m_e     <= s_e;
                s_valid <= 1'b0;
            end
        end else if (m_valid) begin
            if (accept && drain) begin
                m_e <= in_e;
            end else if (accept) begin
                s_e     <= in_e;
                s_valid <= 1'b1;
            end else if (drain) begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            m_e     <= in_e;
            m_valid <= 1'b1;
        end
    end

`ifdef BRANCH_TARGET_STATS_EN
    // A drain in a flush cycle is still a completed transfer, so flush is ignored here
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt_o <= '0;
            taken_cnt_o  <= '0;
        end else if (drain && branch_o) begin
            branch_cnt_o <= branch_cnt_o + 32'd1;
            taken_cnt_o  <= taken_cnt_o + {31'd0, taken_o};
        end
    end
`endif
endmodule

// File: tb/tb_branch_target_stage.sv
// tb_branch_target_stage: vector, corner-case and randomized queue-model checks for branch_target_stage.
module tb_branch_target_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, branch = 1'b0, bne = 1'b0, zero = 1'b0, flush = 1'b0;
    logic        out_valid, out_ready = 1'b0, taken, branch_q, misalign;
    logic [31:0] pc = '0, off = '0, target;
`ifdef BRANCH_TARGET_STATS_EN
    logic [31:0] branch_cnt, taken_cnt;
`endif
    int errors = 0, checks = 0;

    typedef struct {
        logic [31:0] t;
        logic        tk, br, mis;
    } ent_t;

    typedef struct {
        logic [31:0] pc, off;
        logic        br, bne, z;
        logic [31:0] et;
        logic        etk, emis;
    } vec_t;

    vec_t vt[6];
    ent_t q[$];
    ent_t e;

    always #5 clk = ~clk;

    branch_target_stage #(.ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pc_plus4_i(pc), .offset_sl2_i(off), .branch_i(branch), .bne_i(bne), .zero_i(zero),
        .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .target_o(target), .taken_o(taken), .branch_o(branch_q), .misalign_o(misalign)
`ifdef BRANCH_TARGET_STATS_EN
        , .branch_cnt_o(branch_cnt), .taken_cnt_o(taken_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] o, input logic b, input logic n, input logic z);
        in_valid = v; pc = p; off = o; branch = b; bne = n; zero = z;
    endtask

    int bc, tc;
    logic dr, ac;
    logic [31:0] r;

    initial begin
        vt[0] = '{32'h0000_0040, 32'h0000_0010, 1, 0, 1, 32'h0000_0050, 1, 0};
        vt[1] = '{32'h0000_1000, 32'hFFFF_FFF0, 1, 1, 1, 32'h0000_0FF0, 0, 0};
        vt[2] = '{32'hFFFF_FFFC, 32'h0000_0008, 1, 0, 0, 32'h0000_0004, 0, 0};
        vt[3] = '{32'h0000_0100, 32'h0000_0006, 1, 1, 0, 32'h0000_0106, 1, 1};
        vt[4] = '{32'h0000_0200, 32'h0000_0020, 0, 1, 0, 32'h0000_0220, 0, 0};
        vt[5] = '{32'h8000_0000, 32'h8000_0000, 1, 0, 1, 32'h0000_0000, 1, 0};

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_target", target, 0);
        chk("rst_flags", {taken, branch_q, misalign}, 0);
        tick; tick;
        rst_n = 1'b1;
        tick;

        // single-entry vectors, drained the cycle after they appear
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, vt[i].pc, vt[i].off, vt[i].br, vt[i].bne, vt[i].z);
            tick;
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_target", i), target, vt[i].et);
            chk($sformatf("vec%0d_taken", i), taken, vt[i].etk);
            chk($sformatf("vec%0d_branch", i), branch_q, vt[i].br);
            chk($sformatf("vec%0d_mis", i), misalign, vt[i].emis);
            tick;
            chk($sformatf("vec%0d_drained", i), out_valid, 0);
        end

        // backpressure: A, B accepted, C held upstream until room
        out_ready = 1'b0;
        drive(1, 32'h100, 32'h4, 1, 0, 1); tick;
        drive(1, 32'h200, 32'h8, 1, 0, 1); tick;
        chk("bp_full_ready", in_ready, 0);
        drive(1, 32'h300, 32'hC, 1, 0, 1); tick;
        chk("bp_stall_ready", in_ready, 0);
        chk("bp_stall_A", target, 32'h104);
        tick;
        chk("bp_stable_A", {out_valid, target}, {1'b1, 32'h104});
        out_ready = 1'b1; tick;
        chk("bp_B", target, 32'h208);
        chk("bp_B_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk("bp_C", target, 32'h30C);
        tick;
        chk("bp_empty", out_valid, 0);

        // flush while FULL discards both entries and the incoming one
        out_ready = 1'b0;
        drive(1, 32'h400, 32'h4, 1, 0, 1); tick;
        drive(1, 32'h500, 32'h4, 1, 0, 1); tick;
        drive(1, 32'h600, 32'h4, 1, 0, 1); flush = 1'b1; tick;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        out_ready = 1'b1; tick;
        chk("flush_gone", out_valid, 0);

        // misaligned entry, then async reset while it is held
        out_ready = 1'b0;
        drive(1, 32'h700, 32'h6, 1, 1, 1); tick;
        in_valid = 1'b0;
        chk("mis_flag", misalign, 1);
        chk("mis_target", target, 32'h706);
        drive(1, 32'h800, 32'h4, 1, 0, 1); tick;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_data", {target, taken, branch_q, misalign}, 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("arst_after", out_valid, 0);

`ifdef BRANCH_TARGET_STATS_EN
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            // branches 0..4, taken when i < 3; entries 5, 6 are non-branches
            drive(1, 32'h1000, 32'h10, i < 5, 0, i < 3);
            tick;
            in_valid = 1'b0;
            tick;
        end
        chk("stat_branch", branch_cnt, 5);
        chk("stat_taken", taken_cnt, 3);
        out_ready = 1'b0;
        drive(1, 32'h1000, 32'h10, 1, 0, 1); tick;
        in_valid = 1'b0; flush = 1'b1; tick;
        flush = 1'b0;
        chk("stat_flush_b", branch_cnt, 5);
        chk("stat_flush_t", taken_cnt, 3);
`endif

        // randomized traffic against a depth-2 FIFO model
        bc = 5; tc = 3;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            r = $urandom;
            off = (r[1:0] == 2'd0) ? $urandom : ($urandom << 2);
            pc = $urandom;
            r = $urandom;
            in_valid = r[1:0] != 2'd0;
            out_ready = r[3:2] != 2'd0;
            flush = r[8:4] == 5'd0;
            branch = r[9]; bne = r[10]; zero = r[11];
            #3;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                chk("rnd_hs", {out_valid, in_ready}, {q.size() > 0, q.size() < 2});
            end else begin
                checks++;
            end
            if (q.size() > 0)
                chk("rnd_data", {target, taken, branch_q, misalign}, {q[0].t, q[0].tk, q[0].br, q[0].mis});
            dr = q.size() > 0 && out_ready;
            ac = in_valid && q.size() < 2;
            if (dr && q[0].br) begin
                bc++;
                tc += q[0].tk ? 1 : 0;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (dr) void'(q.pop_front());
                if (ac) begin
                    e.t = pc + off;
                    e.tk = branch && (zero != bne);
                    e.br = branch;
                    e.mis = off[1:0] != 2'd0;
                    q.push_back(e);
                end
            end
            tick;
        end
`ifdef BRANCH_TARGET_STATS_EN
        chk("rnd_branch_cnt", branch_cnt, bc);
        chk("rnd_taken_cnt", taken_cnt, tc);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_target_stage.md
Name: branch_target_stage

Overview:
- Pipeline stage directly downstream of the 32-bit shift-left-by-two unit.
- Consumes the already-shifted branch offset and PC+4, computes the branch target and taken decision, and registers them toward the fetch PC mux.
- Valid/ready handshake with a one-entry skid buffer so that backpressure never drops a branch.
- Flush input kills in-flight entries on mispredict or exception.

Parameters:
- ADDR_W, 32, width of PC, offset and target.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  upstream entry valid.
- in_ready_o  output  1  stage can accept an entry this cycle.
- pc_plus4_i  input  ADDR_W  PC+4 of the branch instruction.
- offset_sl2_i  input  ADDR_W  sign-extended offset, already shifted left 2.
- branch_i  input  1  instruction is a conditional branch.
- bne_i  input  1  1 = BNE, 0 = BEQ.
- zero_i  input  1  ALU zero flag for the compare.
- flush_i  input  1  discard all held and incoming entries.
- out_valid_o  output  1  output entry valid.
- out_ready_i  input  1  downstream accepts the entry.
- target_o  output  ADDR_W  pc_plus4 + offset_sl2.
- taken_o  output  1  branch taken.
- branch_o  output  1  registered branch_i.
- misalign_o  output  1  offset_sl2_i[1:0] != 0 for this entry.

Behaviour:
- Arithmetic:
  - target = pc_plus4_i + offset_sl2_i, modulo 2^ADDR_W; wrap-around is silent, no carry out.
  - taken = branch_i & (zero_i ^ bne_i). With branch_i = 0, taken = 0 but target is still computed.
- Storage: main register M (drives outputs) plus skid register S; each is {valid, target, taken, branch, misalign}.
- State is derived from {M.valid, S.valid}:
  - EMPTY: 0,0.
  - ONE: 1,0.
  - FULL: 1,1. The state 0,1 is illegal and never reached.
- Handshake signals:
  - in_ready_o = ~S.valid (purely registered; no combinational path from out_ready_i).
  - Accept: in_valid_i & in_ready_o.
  - Drain: out_valid_o & out_ready_i.
  - out_valid_o = M.valid; data outputs always reflect M.
- Transitions (no flush):
  - EMPTY, accept: M <= input, go to ONE.
  - ONE, accept & drain: M <= input, stay in ONE.
  - ONE, accept & no drain: S <= input, go to FULL.
  - ONE, drain & no accept: go to EMPTY.
  - FULL, drain: M <= S, clear S.valid, go to ONE. No accept is possible in FULL.
  - Any other case: hold.
- Latency: an entry accepted at edge N appears on the outputs after edge N, i.e. one cycle.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Output stability: while out_valid_o = 1 and out_ready_i = 0, every output holds stable.
- flush_i (synchronous, highest priority):
  - Next edge clears M.valid and S.valid.
  - Input presented in the flush cycle is discarded, even if in_ready_o = 1.
  - A drain in the flush cycle still counts as a completed transfer.
- Reset:
  - out_valid_o = 0, taken_o = 0, branch_o = 0, misalign_o = 0, target_o = 0, in_ready_o = 1.
  - Takes effect immediately on rst_i low.
  - Reset asserted mid-operation discards both entries.
- Misalignment: misalign_o only flags the entry; the stage does not stall or alter target_o.

Optional Feature:
- Macro: BRANCH_TARGET_STATS_EN.
- When defined:
  - Adds output ports branch_cnt_o [31:0] and taken_cnt_o [31:0].
  - On each drain with branch_o = 1, branch_cnt_o increments; taken_cnt_o also increments if taken_o = 1.
  - Both counters wrap at 2^32, reset to 0 on rst_i, and are unaffected by flush_i.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then single BEQ with pc_plus4 = 0x0000_0040, offset = 0x0000_0010, zero = 1, out_ready = 1 -> next cycle out_valid = 1, target = 0x0000_0050, taken = 1.
- BNE with zero = 1, pc_plus4 = 0x0000_1000, offset = 0xFFFF_FFF0 -> target = 0x0000_0FF0, taken = 0; also pc_plus4 = 0xFFFF_FFFC, offset = 0x8 -> target = 0x0000_0004 (wrap).
- out_ready = 0, three valid inputs A, B, C back-to-back -> A, B accepted, in_ready = 0 on the third cycle, C held upstream; then out_ready = 1 -> outputs A, B, C in order, each stable while stalled.
- FULL state, assert flush with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, flushed input never appears.
- offset = 0x0000_0006 -> misalign_o = 1, target = pc_plus4 + 6; assert rst_i low mid-transfer -> out_valid = 0 immediately.
- With BRANCH_TARGET_STATS_EN: drain 5 branches (3 taken) and 2 non-branches -> branch_cnt = 5, taken_cnt = 3; flush leaves the counts unchanged.
